// File: rtl/pwm_led_pkg.sv
// Shared definitions for the multi-channel PWM LED driver.
// Provides the per-channel mode encodings, the breathe-direction type and
// a helper that sizes the channel-select field of the write port.
package pwm_led_pkg;

    localparam logic MODE_STATIC  = 1'b0;
    localparam logic MODE_BREATHE = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // A single channel still needs a one-bit select field.
    function automatic int unsigned ch_idx_width(input int unsigned num_ch);
        int unsigned w;
        w = unsigned'($clog2(num_ch));
        return (num_ch > 1) ? w : 1;
    endfunction

endpackage

// File: rtl/pwm_led_channel.sv
// One PWM channel: shadow duty register, active duty register, breathe
// direction bit and the output comparator.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   cnt_nxt_i  period index of the next output cycle
//   wrap_i     high in the last cycle of a period; active duty reloads here
//   mode_i     0 = static, 1 = breathe (only looked at on wrap)
//   wr_en_i    shadow write strobe (already decoded for this channel)
//   wr_data_i  shadow write data
//   pwm_o      registered PWM output
module pwm_led_channel
    import pwm_led_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned FADE_STEP     = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [COUNTER_WIDTH-1:0] cnt_nxt_i,
    input  logic                     wrap_i,
    input  logic                     mode_i,
    input  logic                     wr_en_i,
    input  logic [COUNTER_WIDTH-1:0] wr_data_i,
    output logic                     pwm_o
);

    localparam int unsigned SumW = COUNTER_WIDTH + 1;
    localparam logic [SumW-1:0] Step = SumW'(FADE_STEP);

    logic [COUNTER_WIDTH-1:0] shadow_q, shadow_d;
    logic [COUNTER_WIDTH-1:0] active_q, active_d;
    dir_e                     dir_q, dir_d;
    logic                     pwm_q;

    // One extra bit so active + step can never wrap around.
    logic [SumW-1:0] up_sum;
    logic [SumW-1:0] dn_diff;

    always_comb begin
        shadow_d = wr_en_i ? wr_data_i : shadow_q;
        active_d = active_q;
        dir_d    = dir_q;
        up_sum   = {1'b0, active_q} + Step;
        dn_diff  = {1'b0, active_q} - Step;

        // Reload uses shadow_q, so a write in the wrap cycle waits a period.
        if (wrap_i) begin
            case (mode_i)
                MODE_STATIC: begin
                    active_d = shadow_q;
                    dir_d    = DIR_UP;
                end
                MODE_BREATHE: begin
                    if (dir_q == DIR_UP) begin
                        if (up_sum >= {1'b0, shadow_q}) begin
                            active_d = shadow_q;
                            dir_d    = DIR_DOWN;
                        end else begin
                            active_d = up_sum[COUNTER_WIDTH-1:0];
                        end
                    end else begin
                        if ({1'b0, active_q} <= Step) begin
                            active_d = '0;
                            dir_d    = DIR_UP;
                        end else begin
                            active_d = dn_diff[COUNTER_WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            active_q <= '0;
            dir_q    <= DIR_UP;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            dir_q    <= dir_d;
            // Compare against next-state values so the registered output
            // lines up with the period index of the cycle it drives.
            pwm_q    <= (cnt_nxt_i < active_d);
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_led_multi.sv
// Multi-channel PWM LED driver. A shared period counter feeds NUM_CH
// independent channels, each with a double-buffered duty and a static or
// breathe mode.
// Ports:
//   clk_in        system clock, rising edge
//   rst_in        synchronous active-high reset
//   duty_wr_en    shadow duty write strobe
//   duty_wr_ch    target channel; out-of-range indices are ignored
//   duty_wr_data  duty (static) or ceiling (breathe), in counts
//   mode_in       per-channel mode, sampled at the period wrap
//   period_start  one-cycle pulse in period index 0
//   pwm_out       registered PWM outputs
module pwm_led_multi
    import pwm_led_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned MAX_COUNT     = 200,
    parameter int unsigned FADE_STEP     = 1
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              duty_wr_en,
    input  logic [ch_idx_width(NUM_CH)-1:0]   duty_wr_ch,
    input  logic [COUNTER_WIDTH-1:0]          duty_wr_data,
    input  logic [NUM_CH-1:0]                 mode_in,
    output logic                              period_start,
    output logic [NUM_CH-1:0]                 pwm_out
);

    localparam int unsigned IdxW = ch_idx_width(NUM_CH);
    localparam logic [COUNTER_WIDTH-1:0] CntLast = COUNTER_WIDTH'(MAX_COUNT - 1);

    // cnt_q is the period index of the output cycle currently on the pins.
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    // Low only in the cycle after reset; makes the first released edge
    // produce index 0 rather than index 1.
    logic                     run_q;
    logic                     period_start_q;
    logic                     wrap;
    logic                     wr_ok;

    assign wrap  = run_q && (cnt_q == CntLast);
    assign wr_ok = duty_wr_en && (32'(duty_wr_ch) < NUM_CH);

    always_comb begin
        cnt_d = cnt_q + COUNTER_WIDTH'(1);
        if (!run_q || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q          <= '0;
            run_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            run_q          <= 1'b1;
            period_start_q <= (cnt_d == '0);
        end
    end

    assign period_start = period_start_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pwm_led_channel #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .FADE_STEP     (FADE_STEP)
        ) u_ch (
            .clk_i     (clk_in),
            .rst_i     (rst_in),
            .cnt_nxt_i (cnt_d),
            .wrap_i    (wrap),
            .mode_i    (mode_in[c]),
            .wr_en_i   (wr_ok && (duty_wr_ch == IdxW'(c))),
            .wr_data_i (duty_wr_data),
            .pwm_o     (pwm_out[c])
        );
    end

endmodule

// File: tb/tb_pwm_led_multi.sv
module tb_pwm_led_multi;

    localparam int Period = 200;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       duty_wr_en = 1'b0;
    logic [1:0] duty_wr_ch = '0;
    logic [7:0] duty_wr_data = '0;
    logic [3:0] mode_in = '0;
    logic       period_start;
    logic [3:0] pwm_out;

    // Small second instance with a non-power-of-two channel count so an
    // out-of-range channel index is expressible.
    logic       wr3_en = 1'b0;
    logic [1:0] wr3_ch = '0;
    logic [2:0] wr3_data = '0;
    logic [2:0] mode3 = '0;
    logic       ps3;
    logic [2:0] pwm3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_led_multi #(
        .NUM_CH        (4),
        .COUNTER_WIDTH (8),
        .MAX_COUNT     (200),
        .FADE_STEP     (50)
    ) u_dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .duty_wr_en   (duty_wr_en),
        .duty_wr_ch   (duty_wr_ch),
        .duty_wr_data (duty_wr_data),
        .mode_in      (mode_in),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    pwm_led_multi #(
        .NUM_CH        (3),
        .COUNTER_WIDTH (3),
        .MAX_COUNT     (4),
        .FADE_STEP     (1)
    ) u_dut3 (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .duty_wr_en   (wr3_en),
        .duty_wr_ch   (wr3_ch),
        .duty_wr_data (wr3_data),
        .mode_in      (mode3),
        .period_start (ps3),
        .pwm_out      (pwm3)
    );

    typedef struct {
        int              wr_at;
        logic [1:0]      ch;
        logic [7:0]      data;
        int              nwr;
        logic [3:0][7:0] exp_hi;
    } vec_t;

    vec_t vecs[11];
    int   br_hi[7];

    function automatic logic [3:0][7:0] hi4(input int a0, input int a1, input int a2,
                                            input int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic vec_t mkvec(input int wr_at, input int ch, input int data,
                                   input int nwr, input logic [3:0][7:0] e);
        vec_t v;
        v.wr_at  = wr_at;
        v.ch     = 2'(ch);
        v.data   = 8'(data);
        v.nwr    = nwr;
        v.exp_hi = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Entered while sampling period index 0; leaves at the next index 0.
    // Optionally writes nwr consecutive values (data, data+1, ...) to one
    // channel starting at index wr_at.
    task automatic run_period(input string name, input logic [3:0][7:0] exp_hi,
                              input int wr_at, input logic [1:0] wr_ch,
                              input logic [7:0] wr_data, input int nwr);
        int ps_bad;
        int bad[4];
        int hi[4];
        ps_bad = 0;
        for (int c = 0; c < 4; c++) begin
            bad[c] = 0;
            hi[c]  = 0;
        end
        for (int p = 0; p < Period; p++) begin
            if (period_start !== (p == 0)) ps_bad++;
            for (int c = 0; c < 4; c++) begin
                if (pwm_out[c] === 1'b1) hi[c]++;
                if (pwm_out[c] !== (p < int'(exp_hi[c]))) bad[c]++;
            end
            if (nwr > 0 && p >= wr_at && p < wr_at + nwr) begin
                duty_wr_en   = 1'b1;
                duty_wr_ch   = wr_ch;
                duty_wr_data = wr_data + 8'(p - wr_at);
            end else begin
                duty_wr_en = 1'b0;
            end
            tick();
        end
        duty_wr_en = 1'b0;
        chk($sformatf("%s period_start bad cycles", name), ps_bad, 0);
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (bad[c] != 0) begin
                n_err++;
                $display("FAIL %s ch%0d: high cycles got %0d, want %0d first cycles (%0d bad)",
                         name, c, hi[c], (int'(exp_hi[c]) > Period) ? Period : int'(exp_hi[c]),
                         bad[c]);
            end
        end
    endtask

    initial begin
        int cnt;

        vecs[0]  = mkvec(73,  1, 50,  1, hi4(0, 0, 0, 0));
        vecs[1]  = mkvec(120, 0, 0,   1, hi4(0, 50, 0, 0));
        vecs[2]  = mkvec(5,   2, 200, 1, hi4(0, 50, 0, 0));
        vecs[3]  = mkvec(199, 3, 255, 1, hi4(0, 50, 200, 0));
        vecs[4]  = mkvec(199, 1, 80,  1, hi4(0, 50, 200, 0));
        vecs[5]  = mkvec(198, 0, 1,   1, hi4(0, 50, 200, 200));
        vecs[6]  = mkvec(0,   0, 0,   0, hi4(1, 80, 200, 200));
        vecs[7]  = mkvec(10,  2, 100, 1, hi4(1, 80, 200, 200));
        vecs[8]  = mkvec(0,   0, 0,   0, hi4(1, 80, 100, 200));
        vecs[9]  = mkvec(60,  1, 30,  3, hi4(1, 80, 100, 200));
        vecs[10] = mkvec(0,   0, 0,   0, hi4(1, 32, 100, 200));
        br_hi = '{50, 100, 120, 70, 20, 0, 50};

        // Reset state
        repeat (3) tick();
        chk("reset period_start", int'(period_start), 0);
        chk("reset pwm_out", int'(pwm_out), 0);
        rst_in = 1'b0;
        tick();

        // Idle: no writes, outputs low, pulse at index 0 of each period
        run_period("idle0", hi4(0, 0, 0, 0), 0, 2'd0, 8'd0, 0);
        run_period("idle1", hi4(0, 0, 0, 0), 0, 2'd0, 8'd0, 0);

        // Static-duty vector table
        for (int i = 0; i < 11; i++) begin
            run_period($sformatf("vec%0d", i), vecs[i].exp_hi, vecs[i].wr_at, vecs[i].ch,
                       vecs[i].data, vecs[i].nwr);
        end

        // Breathe on ch0, step 50, ceiling 120
        run_period("br_pre", hi4(1, 32, 100, 200), 20, 2'd0, 8'd0, 1);
        mode_in = 4'b0001;
        run_period("br_set", hi4(0, 32, 100, 200), 100, 2'd0, 8'd120, 1);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                // Back to static; this wrap loads the freshly written 150
                mode_in = 4'b0000;
                run_period($sformatf("br%0d", i), hi4(br_hi[i], 32, 100, 200), 30, 2'd0,
                           8'd150, 1);
            end else begin
                run_period($sformatf("br%0d", i), hi4(br_hi[i], 32, 100, 200), 0, 2'd0,
                           8'd0, 0);
            end
        end

        // Reset at period index 100 with ch0 = 150
        cnt = 0;
        for (int p = 0; p <= 100; p++) begin
            if (pwm_out[0] !== (p < 150)) cnt++;
            if (p == 100) rst_in = 1'b1;
            tick();
        end
        chk("pre-reset ch0 bad cycles", cnt, 0);
        chk("mid reset pwm_out", int'(pwm_out), 0);
        chk("mid reset period_start", int'(period_start), 0);
        rst_in = 1'b0;
        tick();
        chk("restart period_start", int'(period_start), 1);
        chk("restart pwm_out", int'(pwm_out), 0);
        run_period("post_rst", hi4(0, 0, 0, 0), 50, 2'd0, 8'd7, 1);
        run_period("post_rst_wr", hi4(7, 0, 0, 0), 0, 2'd0, 8'd0, 0);

        // Out-of-range channel write on the 3-channel instance
        wr3_en = 1'b1;
        wr3_ch = 2'd3;
        wr3_data = 3'd4;
        tick();
        wr3_en = 1'b0;
        repeat (10) tick();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (pwm3 !== 3'b000) cnt++;
            tick();
        end
        chk("ch3 of 3 ignored, bad cycles", cnt, 0);

        wr3_en = 1'b1;
        wr3_ch = 2'd2;
        tick();
        wr3_en = 1'b0;
        repeat (10) tick();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (pwm3 !== 3'b100) cnt++;
            tick();
        end
        chk("3ch ch2 full duty, bad cycles", cnt, 0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (ps3 === 1'b1) cnt++;
            tick();
        end
        chk("3ch period_start pulses in 8", cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
